// File: rtl/multicycle_stage_sequencer_if.sv
// Handshake bundle between the multicycle sequencer and the datapath/memory side.
// master = sequencer (drives strobes/requests), slave = datapath and memory.
interface multicycle_stage_sequencer_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 run;
  logic [6:0]           opcode;
  logic                 branch_taken;
  logic                 mem_ready;
  logic                 mem_read;
  logic                 mem_write;
  logic                 pc_inc;
  logic                 pc_load;
  logic                 ir_ena;
  logic                 ab_ena;
  logic                 alu_out_ena;
  logic                 mdr_ena;
  logic                 rf_we;
  logic [2:0]           state;
  logic                 trap;
  logic                 bus_err;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    input  run, opcode, branch_taken, mem_ready,
    output mem_read, mem_write, pc_inc, pc_load, ir_ena, ab_ena,
           alu_out_ena, mdr_ena, rf_we, state, trap, bus_err, retired
  );

  modport slave (
    output run, opcode, branch_taken, mem_ready,
    input  mem_read, mem_write, pc_inc, pc_load, ir_ena, ab_ena,
           alu_out_ena, mdr_ena, rf_we, state, trap, bus_err, retired
  );
endinterface

// File: rtl/multicycle_stage_sequencer.sv
// Control FSM for the multicycle RV32I core: owns every datapath register
// enable, the memory request handshake and the retired-instruction counter.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   FETCH     | idle until run; then mem_read until mem_ready (IR load, PC+4)
//   DECODE    | load A/B operands, reject illegal opcodes
//   EXECUTE   | load ALUOut, PC target for jumps / taken branches
//   MEMORY    | LOAD: mem_read until mem_ready (MDR load); STORE: mem_write
//   WRITEBACK | register-file write
//   TRAP      | sticky fault; only reset leaves it
module multicycle_stage_sequencer #(
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_stage_sequencer_if.master bus
);

  // Wait counter only needs to reach TIMEOUT-1: the cycle that would take it
  // to TIMEOUT is the one that traps.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd7
  } state_t;

  state_t               r_state;
  logic [WAIT_W-1:0]    r_wait;
  logic                 r_fetch_busy;
  logic                 r_trap;
  logic                 r_bus_err;
  logic [CNT_WIDTH-1:0] r_retired;

  logic w_legal;
  logic w_is_store;
  logic w_is_branch;
  logic w_is_jump;
  logic w_is_mem;
  logic w_fetch_req;
  logic w_req;
  logic w_done;
  logic w_timeout;

  logic w_mem_read;
  logic w_mem_write;
  logic w_ir_ena;
  logic w_ab_ena;
  logic w_alu_out_ena;
  logic w_pc_load;
  logic w_mdr_ena;
  logic w_rf_we;

  // Opcode classification straight from the IR output.
  always_comb begin
    w_legal = 1'b0;
    case (bus.opcode)
      OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: w_legal = 1'b1;
      default:                               w_legal = 1'b0;
    endcase
  end

  assign w_is_store  = (bus.opcode == OPC_STORE);
  assign w_is_branch = (bus.opcode == OPC_BRANCH);
  assign w_is_jump   = (bus.opcode == OPC_JAL) || (bus.opcode == OPC_JALR);
  assign w_is_mem    = (bus.opcode == OPC_LOAD) || w_is_store;

  // Once a fetch request has gone out, r_fetch_busy keeps it alive even if run drops.
  assign w_fetch_req = (r_state == S_FETCH) && (bus.run || r_fetch_busy);
  assign w_req       = w_fetch_req || (r_state == S_MEMORY);
  assign w_done      = w_req && bus.mem_ready;
  assign w_timeout   = w_req && !bus.mem_ready && (r_wait == WAIT_LAST);

  // State, wait counter, sticky flags and retired count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_FETCH;
      r_wait       <= '0;
      r_fetch_busy <= 1'b0;
      r_trap       <= 1'b0;
      r_bus_err    <= 1'b0;
      r_retired    <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_done) begin
            r_state      <= S_DECODE;
            r_wait       <= '0;
            r_fetch_busy <= 1'b0;
          end else if (w_timeout) begin
            r_state      <= S_TRAP;
            r_trap       <= 1'b1;
            r_bus_err    <= 1'b1;
            r_wait       <= '0;
            r_fetch_busy <= 1'b0;
          end else if (w_fetch_req) begin
            r_wait       <= r_wait + WAIT_W'(1);
            r_fetch_busy <= 1'b1;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXECUTE;
          end else begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
          end
        end
        S_EXECUTE: begin
          if (w_is_mem) begin
            r_state <= S_MEMORY;
          end else if (w_is_branch) begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + CNT_WIDTH'(1);
          end else begin
            r_state <= S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          if (w_done) begin
            r_wait <= '0;
            if (w_is_store) begin
              r_state   <= S_FETCH;
              r_retired <= r_retired + CNT_WIDTH'(1);
            end else begin
              r_state <= S_WRITEBACK;
            end
          end else if (w_timeout) begin
            r_state   <= S_TRAP;
            r_trap    <= 1'b1;
            r_bus_err <= 1'b1;
            r_wait    <= '0;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_WRITEBACK: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + CNT_WIDTH'(1);
        end
        S_TRAP: begin
          r_state <= S_TRAP;
        end
        default: begin
          r_state <= S_TRAP;
          r_trap  <= 1'b1;
        end
      endcase
    end
  end

  // Strobes and requests decoded from state and inputs; forced low while in reset.
  always_comb begin
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_ena      = 1'b0;
    w_ab_ena      = 1'b0;
    w_alu_out_ena = 1'b0;
    w_pc_load     = 1'b0;
    w_mdr_ena     = 1'b0;
    w_rf_we       = 1'b0;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          w_mem_read = w_fetch_req;
          w_ir_ena   = w_fetch_req && bus.mem_ready;
        end
        S_DECODE:  w_ab_ena = 1'b1;
        S_EXECUTE: begin
          w_alu_out_ena = 1'b1;
          w_pc_load     = w_is_jump || (w_is_branch && bus.branch_taken);
        end
        S_MEMORY: begin
          w_mem_write = w_is_store;
          w_mem_read  = !w_is_store;
          w_mdr_ena   = !w_is_store && bus.mem_ready;
        end
        S_WRITEBACK: w_rf_we = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.mem_read    = w_mem_read;
  assign bus.mem_write   = w_mem_write;
  assign bus.ir_ena      = w_ir_ena;
  assign bus.pc_inc      = w_ir_ena;
  assign bus.ab_ena      = w_ab_ena;
  assign bus.alu_out_ena = w_alu_out_ena;
  assign bus.pc_load     = w_pc_load;
  assign bus.mdr_ena     = w_mdr_ena;
  assign bus.rf_we       = w_rf_we;
  assign bus.state       = r_state;
  assign bus.trap        = r_trap;
  assign bus.bus_err     = r_bus_err;
  assign bus.retired     = r_retired;

endmodule

// File: tb/tb_multicycle_stage_sequencer.sv
// Bench for multicycle_stage_sequencer: per-instruction reference model pushes
// the expected pulse events; a negedge monitor pops and compares them.
module tb_multicycle_stage_sequencer;
  localparam int CW = 3;
  localparam int TO = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // strobe vector order: {ir_ena, pc_inc, ab_ena, alu_out_ena, pc_load, mdr_ena, rf_we}
  localparam logic [6:0] SB_IRPC = 7'b1100000;
  localparam logic [6:0] SB_AB   = 7'b0010000;
  localparam logic [6:0] SB_ALU  = 7'b0001000;
  localparam logic [6:0] SB_PCL  = 7'b0000100;
  localparam logic [6:0] SB_MDR  = 7'b0000010;
  localparam logic [6:0] SB_WB   = 7'b0000001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_stage_sequencer_if #(.CNT_WIDTH(CW)) bus ();
  multicycle_stage_sequencer #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic [6:0]    strb;
    logic          rd;
    logic          wr;
    logic [2:0]    st;
    logic          trp;
    logic          berr;
    logic [3:0]    req;
    logic [CW-1:0] ret;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  model_ret = 0;
  bit  trapped;
  logic [6:0] legal_ops [9] = '{OP_LOAD, OP_STORE, OP_OP, OP_OPIMM, OP_BRANCH,
                                OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    for (int i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ev_t mk_ev(input logic [6:0] strb, input logic rd, input logic wr,
                                input logic [2:0] st, input logic trp, input logic berr,
                                input int req);
    ev_t e;
    e.strb = strb; e.rd = rd; e.wr = wr; e.st = st;
    e.trp = trp; e.berr = berr; e.req = 4'(req); e.ret = CW'(model_ret);
    return e;
  endfunction

  function automatic void retire();
    model_ret = (model_ret + 1) % (1 << CW);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: an event is any strobe, a store completion, or entry into trap.
  int   req_run = 0;
  logic prev_trap = 1'b0;
  always @(negedge clk) begin
    ev_t  obs;
    ev_t  e;
    logic trig;
    if (rst !== 1'b1) begin
      req_run   = 0;
      prev_trap = 1'b0;
    end else begin
      check("rd_wr_exclusive", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
      if (bus.mem_read || bus.mem_write) req_run++;
      obs.strb = {bus.ir_ena, bus.pc_inc, bus.ab_ena, bus.alu_out_ena,
                  bus.pc_load, bus.mdr_ena, bus.rf_we};
      obs.rd   = bus.mem_read;
      obs.wr   = bus.mem_write;
      obs.st   = bus.state;
      obs.trp  = bus.trap;
      obs.berr = bus.bus_err;
      obs.req  = (req_run > 15) ? 4'd15 : 4'(req_run);
      obs.ret  = bus.retired;
      trig = (obs.strb != 7'd0) || (bus.mem_write && bus.mem_ready) || (bus.trap && !prev_trap);
      prev_trap = bus.trap;
      if (trig) begin
        req_run = 0;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got strb=%b st=%0d trap=%b, expected no event",
                   obs.strb, obs.st, obs.trp);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_fail++;
            $display("FAIL event: got strb=%b rd=%b wr=%b st=%0d trap=%b berr=%b req=%0d ret=%0d, expected strb=%b rd=%b wr=%b st=%0d trap=%b berr=%b req=%0d ret=%0d",
                     obs.strb, obs.rd, obs.wr, obs.st, obs.trp, obs.berr, obs.req, obs.ret,
                     e.strb, e.rd, e.wr, e.st, e.trp, e.berr, e.req, e.ret);
          end
        end
      end
    end
  end

  // One instruction: push expected events, then drive the cycle schedule.
  // fd/md = cycles mem_ready stays low; a value >= TO means it never comes.
  task automatic do_instr(input logic [6:0] op, input logic bt, input int n_idle,
                          input int fd, input int md, output bit trp);
    bit legal;
    bit pcl;
    legal = is_legal(op);
    pcl   = (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH && bt);
    trp   = 1'b0;
    if (fd >= TO) begin
      exp_q.push_back(mk_ev(7'd0, 0, 0, 3'd7, 1, 1, TO));
    end else begin
      exp_q.push_back(mk_ev(SB_IRPC, 1, 0, 3'd0, 0, 0, fd + 1));
      exp_q.push_back(mk_ev(SB_AB, 0, 0, 3'd1, 0, 0, 0));
      if (!legal) begin
        exp_q.push_back(mk_ev(7'd0, 0, 0, 3'd7, 1, 0, 0));
      end else begin
        exp_q.push_back(mk_ev(SB_ALU | (pcl ? SB_PCL : 7'd0), 0, 0, 3'd2, 0, 0, 0));
        if (op == OP_BRANCH) begin
          retire();
        end else if (op == OP_LOAD || op == OP_STORE) begin
          if (md >= TO) begin
            exp_q.push_back(mk_ev(7'd0, 0, 0, 3'd7, 1, 1, TO));
          end else if (op == OP_LOAD) begin
            exp_q.push_back(mk_ev(SB_MDR, 1, 0, 3'd3, 0, 0, md + 1));
            exp_q.push_back(mk_ev(SB_WB, 0, 0, 3'd4, 0, 0, 0));
            retire();
          end else begin
            exp_q.push_back(mk_ev(7'd0, 0, 1, 3'd3, 0, 0, md + 1));
            retire();
          end
        end else begin
          exp_q.push_back(mk_ev(SB_WB, 0, 0, 3'd4, 0, 0, 0));
          retire();
        end
      end
    end

    bus.opcode = op;
    bus.branch_taken = bt;
    repeat (n_idle) begin
      bus.run = 1'b0;
      bus.mem_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    bus.run = 1'b1;
    for (int k = 0; k <= fd && k < TO; k++) begin
      bus.mem_ready = (k == fd);
      cyc();
      bus.run = 1'($urandom_range(0, 1));
    end
    if (fd >= TO) begin trp = 1'b1; return; end
    bus.mem_ready = 1'($urandom_range(0, 1));
    cyc();
    if (!legal) begin trp = 1'b1; return; end
    bus.mem_ready = 1'($urandom_range(0, 1));
    cyc();
    if (op == OP_LOAD || op == OP_STORE) begin
      for (int k = 0; k <= md && k < TO; k++) begin
        bus.mem_ready = (k == md);
        bus.run = 1'($urandom_range(0, 1));
        cyc();
      end
      if (md >= TO) begin trp = 1'b1; return; end
      if (op == OP_LOAD) begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        cyc();
      end
    end else if (op != OP_BRANCH) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    bus.run = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    model_ret = 0;
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = OP_OP;
    cyc();
    cyc();
    check("rst_state", {29'd0, bus.state}, 32'd0);
    check("rst_trap", {31'd0, bus.trap}, 32'd0);
    check("rst_bus_err", {31'd0, bus.bus_err}, 32'd0);
    check("rst_retired", {29'd0, bus.retired}, 32'd0);
    check("rst_no_read", {31'd0, bus.mem_read}, 32'd0);
    check("rst_no_ir_ena", {31'd0, bus.ir_ena}, 32'd0);
    rst = 1'b1;
  endtask

  task automatic trap_hold_and_reset(input logic exp_berr);
    for (int i = 0; i < 20; i++) begin
      check("trap_state", {29'd0, bus.state}, 32'd7);
      check("trap_flag", {31'd0, bus.trap}, 32'd1);
      check("trap_bus_err", {31'd0, bus.bus_err}, {31'd0, exp_berr});
      bus.run = 1'($urandom_range(0, 1));
      bus.opcode = 7'($urandom);
      bus.mem_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    do_reset();
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] v;
    if ($urandom_range(0, 19) == 0) begin
      v = 7'($urandom);
      while (is_legal(v)) v = 7'($urandom);
      return v;
    end
    return legal_ops[$urandom_range(0, 8)];
  endfunction

  initial begin
    bus.branch_taken = 1'b0;
    do_reset();

    do_instr(OP_OP, 0, 0, 0, 0, trapped);
    check("retired_after_op", {29'd0, bus.retired}, 32'd1);
    do_instr(OP_LOAD, 0, 0, 0, 3, trapped);
    do_instr(OP_BRANCH, 1, 0, 1, 0, trapped);
    do_instr(OP_BRANCH, 0, 1, 0, 0, trapped);
    check("retired_after_branches", {29'd0, bus.retired}, 32'd4);
    do_instr(OP_JAL, 0, 0, 3, 0, trapped);
    do_instr(OP_STORE, 0, 0, 0, 2, trapped);

    do_reset();
    for (int i = 0; i < 8; i++) do_instr(OP_OPIMM, 0, i % 2, i % 4, 0, trapped);
    check("retired_wrap", {29'd0, bus.retired}, 32'd0);

    do_instr(OP_SYSTEM, 0, 0, 0, 0, trapped);
    if (trapped) trap_hold_and_reset(1'b0);

    do_instr(OP_STORE, 0, 0, 0, TO, trapped);
    if (trapped) trap_hold_and_reset(1'b1);

    do_instr(OP_LUI, 0, 1, TO, 0, trapped);
    if (trapped) trap_hold_and_reset(1'b1);

    // STORE interrupted by reset while waiting in MEMORY.
    exp_q.push_back(mk_ev(SB_IRPC, 1, 0, 3'd0, 0, 0, 1));
    exp_q.push_back(mk_ev(SB_AB, 0, 0, 3'd1, 0, 0, 0));
    exp_q.push_back(mk_ev(SB_ALU, 0, 0, 3'd2, 0, 0, 0));
    bus.opcode = OP_STORE;
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    cyc();
    cyc();
    check("midrst_in_memory", {29'd0, bus.state}, 32'd3);
    check("midrst_write_req", {31'd0, bus.mem_write}, 32'd1);
    cyc();
    rst = 1'b0;
    exp_q.delete();
    model_ret = 0;
    bus.run = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    check("midrst_state", {29'd0, bus.state}, 32'd0);
    check("midrst_write_dropped", {31'd0, bus.mem_write}, 32'd0);
    check("midrst_retired", {29'd0, bus.retired}, 32'd0);

    for (int n = 0; n < 150; n++) begin
      logic [6:0] op;
      int fd;
      int md;
      op = rand_op();
      fd = ($urandom_range(0, 29) == 0) ? TO : int'($urandom_range(0, 3));
      md = ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, 3));
      do_instr(op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), fd, md, trapped);
      if (trapped) trap_hold_and_reset(bus.bus_err === 1'b1 ? 1'b1 : 1'b0);
    end

    bus.run = 1'b0;
    repeat (5) cyc();
    check("events_outstanding", exp_q.size(), 32'd0);
    check("final_retired", {29'd0, bus.retired}, model_ret);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_stage_sequencer.md
Name: multicycle_stage_sequencer

Overview:
- Control FSM for the multicycle RV32I datapath.
- Sequences the single-cycle enable pulses for the IR, the A/B operand doubleRegister pair, ALUOut and MDR.
- Drives the memory request handshake, PC update strobes, register-file write and a retired-instruction counter.
- Sits between instruction decode and the datapath registers; owns every register enable in the core.

Parameters:
- CNT_WIDTH, 32: width of the retired-instruction counter.
- TIMEOUT, 255: maximum cycles to wait for mem_ready before a bus error; must be ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-low reset.
- run  in  1  permits a new instruction fetch.
- opcode  in  7  instruction[6:0] from the IR output.
- branch_taken  in  1  branch comparison result, valid in EXECUTE.
- mem_ready  in  1  memory completes the current read/write this cycle.
- mem_read  out  1  memory read request, held until mem_ready.
- mem_write  out  1  memory write request, held until mem_ready.
- pc_inc  out  1  PC <= PC+4 pulse.
- pc_load  out  1  PC <= ALU target pulse.
- ir_ena  out  1  IR load pulse.
- ab_ena  out  1  operand A/B doubleRegister load pulse.
- alu_out_ena  out  1  ALUOut load pulse.
- mdr_ena  out  1  MDR load pulse.
- rf_we  out  1  register-file write pulse.
- state  out  3  current state encoding.
- trap  out  1  sticky fault flag.
- bus_err  out  1  sticky: the trap was caused by a timeout.
- retired  out  CNT_WIDTH  count of completed instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=7.
- rst=0 at a clock edge: state=FETCH, retired=0, trap=0, bus_err=0, wait counter=0. All strobes and requests are combinational from state and inputs, so all are 0 during reset.
- Opcode classes:
  - LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011
  - BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111
  - Any other value is illegal, including SYSTEM.
- FETCH:
  - run=0: idle, no outputs asserted.
  - run=1: mem_read=1.
  - Cycle with mem_ready=1: ir_ena=1 and pc_inc=1 in that same cycle; next state DECODE.
- DECODE: ab_ena=1 for exactly one cycle. Next state TRAP if opcode is illegal, else EXECUTE.
- EXECUTE: alu_out_ena=1.
  - JAL/JALR: pc_load=1.
  - BRANCH: pc_load=branch_taken.
  - Next state: LOAD/STORE → MEMORY; BRANCH → FETCH; all others → WRITEBACK.
- MEMORY:
  - LOAD: mem_read=1 until mem_ready; mdr_ena=1 in the mem_ready cycle; then WRITEBACK.
  - STORE: mem_write=1 until mem_ready; then FETCH.
- WRITEBACK: rf_we=1 for one cycle; next state FETCH.
- Strobe rules:
  - Every *_ena, rf_we, pc_inc and pc_load is a single-cycle pulse per instruction.
  - mem_read and mem_write are never asserted together.
- retired:
  - Increments by 1 on every transition into FETCH from EXECUTE, MEMORY or WRITEBACK.
  - Wraps modulo 2^CNT_WIDTH.
  - Does not count on entry to TRAP.
- Wait counter:
  - Counts cycles with a request outstanding and mem_ready=0.
  - Clears when mem_ready=1 or on a state change.
  - Reaching TIMEOUT with mem_ready still 0: next state TRAP, bus_err=1, request drops.
  - A mem_ready in the same cycle as the counter reaching TIMEOUT counts as success.
- TRAP:
  - trap=1, all strobes 0.
  - Exits only via rst=0.
  - run and opcode are ignored.
- run is sampled only in FETCH before a request starts. Once mem_read is asserted in FETCH, run=0 does not abort the fetch.
- Reset mid-operation (e.g. during MEMORY with mem_write=1): the request drops the next cycle, state=FETCH, no strobe issued.

Test Plan:
- Reset with rst=0 for 2 cycles, run=1, OP opcode 0110011, mem_ready=1 → states 0,1,2,4,0 in 5 cycles; pulse sequence ir_ena/pc_inc, ab_ena, alu_out_ena, rf_we; retired=1.
- LOAD with mem_ready delayed 3 cycles in MEMORY → mem_read held 4 cycles, then mdr_ena pulse, then WRITEBACK rf_we; retired +1.
- BRANCH with branch_taken=1, then a BRANCH with branch_taken=0 → pc_load=1 in the first EXECUTE only; both return to FETCH without rf_we; retired +2.
- Opcode 1110011 → after DECODE, state=7 and trap=1; holds for 20 cycles regardless of run; rst=0 clears to FETCH with trap=0.
- TIMEOUT=4, STORE with mem_ready never asserted → mem_write high 4 cycles, then TRAP with bus_err=1 and mem_write=0.
- CNT_WIDTH=3, 8 OP-IMM instructions → retired wraps to 0. Separately, rst=0 asserted during STORE MEMORY → FETCH next cycle with mem_write=0.
